// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, single mid-bit sample per bit,
// one-cycle new_data / frame_err pulses, busy decoded from the FSM state.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int N  = CLK_FREQ / BAUD;
    localparam int TW = $clog2(N) + 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(N / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(N - 1);

    if (N < 4) begin : g_n_check
        $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    logic [1:0]      sync;
    logic            rxs;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    assign rxs  = sync[1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    // Timer counts from 0 after each sample point; START samples at the
    // half-bit mark, DATA/STOP one full bit after the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            new_data  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            new_data  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        timer <= '0;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer          <= '0;
                        shreg[bit_idx] <= rxs;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rxs) begin
                            data     <= shreg;
                            new_data <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes queued as frames are sent and
// checked against each new_data pulse.
module tb_uart_rx;

    localparam int N   = 100;
    // 2 synchronizer flops + 1 detect edge, then half bit + 9 full bits.
    localparam int LAT = 3 + N / 2 + 9 * N;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       new_data;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int nd_count = 0;
    int fe_count = 0;
    int start_cyc = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] exp_q[$];
    int nd_times[$];
    logic prev_nd = 1'b0;
    logic prev_fe = 1'b0;

    uart_rx #(
        .CLK_FREQ(100000000),
        .BAUD    (1000000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .new_data (new_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pulse is checked when the DUT produces it.
    always @(posedge clk) begin
        #1;
        if (new_data === 1'b1 || frame_err === 1'b1) begin
            check("pulse_exclusive", {31'd0, new_data & frame_err}, 32'd0);
        end
        if (new_data === 1'b1) begin
            nd_count++;
            nd_times.push_back(cyc);
            check("new_data_width", {31'd0, prev_nd}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_new_data", 32'd1, 32'd0);
            end else begin
                exp_data = exp_q.pop_front();
                check("data", {24'd0, data}, {24'd0, exp_data});
            end
        end
        if (frame_err === 1'b1) begin
            fe_count++;
            check("frame_err_width", {31'd0, prev_fe}, 32'd0);
            check("data_hold_on_frame_err", {24'd0, data}, {24'd0, exp_data});
        end
        prev_nd = new_data;
        prev_fe = frame_err;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bc);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bc) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bc) @(negedge clk);
    endtask

    initial begin
        int nd0;
        int fe0;
        int s;
        logic [7:0] abort_byte;

        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_new_data", {31'd0, new_data}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame 0xA5 with exact latency check
        nd0 = nd_count; fe0 = fe_count;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, N);
        s = start_cyc;
        repeat (20) @(negedge clk);
        check("a5_pulses", nd_count - nd0, 32'd1);
        check("a5_no_frame_err", fe_count - fe0, 32'd0);
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        check("a5_latency", nd_times[$] - s, LAT);

        // Back-to-back 0x00 then 0xFF, no idle gap
        nd0 = nd_count; fe0 = fe_count;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, N);
        send_frame(8'hFF, 1'b1, N);
        repeat (20) @(negedge clk);
        check("b2b_pulses", nd_count - nd0, 32'd2);
        check("b2b_no_frame_err", fe_count - fe0, 32'd0);
        check("b2b_gap", nd_times[$] - nd_times[$-1], 10 * N);
        check("b2b_last_data", {24'd0, data}, 32'hFF);

        // Start-bit glitch: 30 cycles low
        nd0 = nd_count; fe0 = fe_count;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_during", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_after", {31'd0, busy}, 32'd0);
        check("glitch_no_new_data", nd_count - nd0, 32'd0);
        check("glitch_no_frame_err", fe_count - fe0, 32'd0);

        // Framing error followed by a long break
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        repeat (5) @(negedge clk);
        nd0 = nd_count; fe0 = fe_count;
        send_frame(8'h3C, 1'b0, N);
        repeat (3000) @(negedge clk);
        check("ferr_pulses", fe_count - fe0, 32'd1);
        check("ferr_no_new_data", nd_count - nd0, 32'd0);
        check("ferr_data_unchanged", {24'd0, data}, 32'h00);
        check("ferr_busy_in_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("ferr_busy_rx_high_2", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        check("ferr_busy_released", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("ferr_single_pulse", fe_count - fe0, 32'd1);

        // Reset during data bit 4 of 0x55, then 0x81
        nd0 = nd_count; fe0 = fe_count;
        abort_byte = 8'h55;
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            repeat (N) @(negedge clk);
        end
        rx = abort_byte[4];
        repeat (N / 2) @(negedge clk);
        check("abort_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        rx = 1'b1;
        check("abort_busy_after_rst", {31'd0, busy}, 32'd0);
        check("abort_data_cleared", {24'd0, data}, 32'h00);
        repeat (50) @(negedge clk);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, N);
        repeat (20) @(negedge clk);
        check("abort_pulses", nd_count - nd0, 32'd1);
        check("abort_no_frame_err", fe_count - fe0, 32'd0);
        check("abort_next_data", {24'd0, data}, 32'h81);

        // Baud tolerance: 2% fast then 2% slow
        nd0 = nd_count; fe0 = fe_count;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, N - N / 50);
        repeat (20) @(negedge clk);
        check("fast_data", {24'd0, data}, 32'h5A);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, N + N / 50);
        repeat (20) @(negedge clk);
        check("slow_data", {24'd0, data}, 32'h5A);
        check("tol_pulses", nd_count - nd0, 32'd2);
        check("tol_no_frame_err", fe_count - fe0, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 1000000, serial bit rate in bits/s.
REQ-003 SHALL derive local constant N = CLK_FREQ/BAUD (integer floor), clocks per bit; N < 4 SHALL be rejected at elaboration.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line (usb_rx), idle high.
REQ-007 SHALL have port data  output  8  last correctly received byte.
REQ-008 SHALL have port new_data  output  1  one-cycle pulse, data updated.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); "rxs" below is the second flop output.
REQ-012 SHALL frame 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a bit-timer counter (width ceil(log2(N))+1) and a 3-bit bit index.
REQ-014 IDLE: when rxs==0 in cycle t, SHALL enter START with timer cleared; otherwise remain.
REQ-015 START: SHALL sample rxs at cycle t+floor(N/2); sample 1 -> IDLE (glitch, no output pulse); sample 0 -> DATA, timer cleared, index 0.
REQ-016 DATA: bit i (0..7) SHALL be sampled at cycle t+floor(N/2)+(i+1)*N into shift-register position i; after bit 7 -> STOP.
REQ-017 STOP: SHALL sample rxs at cycle t+floor(N/2)+9*N.
REQ-018 Stop sample 1: data SHALL load the shift register and new_data SHALL be 1 for exactly the next cycle; state -> IDLE.
REQ-019 Stop sample 0: frame_err SHALL be 1 for exactly the next cycle, data SHALL NOT change; state -> WAIT_HIGH.
REQ-020 WAIT_HIGH: SHALL remain until rxs==1, then -> IDLE (a held-low break produces one frame_err, no further frames).
REQ-021 new_data and frame_err SHALL never be 1 in the same cycle.
REQ-022 busy SHALL be 1 in every state except IDLE, combinationally decoded from state.
REQ-023 A new start edge arriving in the cycle IDLE is re-entered SHALL be accepted (back-to-back frames, no dead cycle required beyond the stop sample).
REQ-024 Between sample points rxs SHALL be ignored (no oversampled majority vote).
REQ-025 Design SHALL have no handshake back-pressure; consumer must take data on new_data.

Reset
REQ-026 While rst is 1 at a clock edge: state IDLE, timer 0, index 0, shift register 0, data 8'h00, new_data 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-027 rst asserted mid-frame SHALL abort the frame with no new_data/frame_err pulse; reception restarts at the next falling edge after rst deasserts.
REQ-028 rst SHALL override all other inputs in the same cycle.

Verification (defaults, N=100)
REQ-029 Send 0xA5 8N1 at 1 Mbaud -> single new_data pulse, data==8'hA5, frame_err never 1, busy low after.
REQ-030 Send 0x00 then 0xFF back-to-back (no idle gap) -> two new_data pulses about 1000 cycles apart, data 8'h00 then 8'hFF.
REQ-031 Drive rx low 30 cycles then high -> no new_data, no frame_err, busy returns to 0 by cycle ~52 after edge.
REQ-032 Send 0x3C with stop bit 0, then hold rx low 3000 cycles, then high -> exactly one frame_err pulse, data unchanged (8'h00 after reset), busy high until rx high + 2 cycles.
REQ-033 Assert rst for 1 cycle during data bit 4 of 0x55, then send 0x81 -> no pulse for aborted frame, one new_data with data==8'h81.
REQ-034 Send 0x5A with baud 2% fast and 2% slow -> data==8'h5A in both cases.
